// File: rtl/irq_collect5.sv
// Five-source interrupt collector: input stage, edge/level detect, pending latch, drop counter.
// Define IRQ_COLLECT_SYNC_EN for a 2-flop REQ synchroniser (+1 cycle latency).
module irq_collect5 #(
    parameter logic [4:0]  EDGE_SEL = 5'b11111,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [4:0]       REQ,
    input  logic [4:0]       MASK,
    input  logic             ACK,
    input  logic [2:0]       ACK_ID,
    input  logic             CNT_CLR,
    output logic [4:0]       PEND,
    output logic             IRQ,
    output logic             VALID,
    output logic [2:0]       ID,
    output logic [CNT_W-1:0] DROP_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [4:0]       s_q;
    logic [4:0]       prev_q;
    logic [4:0]       pend_q;
    logic [4:0]       pend_d;
    logic [4:0]       evt;
    logic [4:0]       clr;
    logic [4:0]       drop;
    logic [2:0]       drop_num;
    logic [16:0]      cnt_sum;
    logic             irq_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifdef IRQ_COLLECT_SYNC_EN
    logic [4:0] sync_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q <= '0;
            s_q    <= '0;
        end else begin
            sync_q <= REQ;
            s_q    <= sync_q;
        end
    end
`else
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s_q <= '0;
        end else begin
            s_q <= REQ;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            prev_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= s_q;
            pend_q <= pend_d;
            irq_q  <= VALID;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        evt      = (EDGE_SEL & s_q & ~prev_q) | (~EDGE_SEL & s_q);
        clr      = '0;
        for (int i = 0; i < 5; i++) begin
            clr[i] = ACK && (ACK_ID == 3'(i));
        end
        // Set wins over a same-cycle clear so no event is lost.
        pend_d   = evt | (pend_q & ~clr);
        drop     = EDGE_SEL & evt & pend_q & ~clr;
        drop_num = '0;
        for (int i = 0; i < 5; i++) begin
            drop_num = drop_num + 3'(drop[i]);
        end
    end

    always_comb begin
        cnt_sum = 17'(cnt_q) + 17'(drop_num);
        if (CNT_CLR) begin
            cnt_d = '0;
        end else if (cnt_sum > 17'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        PEND  = pend_q & MASK;
        VALID = |PEND;
        ID    = '0;
        // Descending scan leaves the lowest pending index.
        for (int i = 4; i >= 0; i--) begin
            if (PEND[i]) begin
                ID = 3'(i);
            end
        end
    end

    assign IRQ      = irq_q;
    assign DROP_CNT = cnt_q;

endmodule
